// File: rtl/spi_pkg.sv
// spi_pkg: shared SPI mode decode and master FSM state type.
package spi_pkg;

    typedef enum logic [2:0] {S_IDLE, S_LEAD, S_SHIFT, S_TRAIL, S_GAP} spi_mst_state_t;

    function automatic logic spi_cpol(input int mode);
        return mode == 2 || mode == 3;
    endfunction

    function automatic logic spi_cpha(input int mode);
        return mode == 1 || mode == 3;
    endfunction

endpackage

// File: rtl/spi_clkgen.sv
// spi_clkgen: SClk half-period divider, active only while the master is shifting.
module spi_clkgen #(
    parameter int   CLK_DIV = 4,
    parameter logic CPOL    = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic edge_tick,
    output logic leading,
    output logic sclk
);
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] div;

    // The first tick lands on the first enabled cycle, so edge 1 follows LEAD with no slack.
    assign edge_tick = en && div == '0;
    assign leading   = sclk == CPOL;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            div  <= '0;
            sclk <= CPOL;
        end else begin
            div  <= en ? (div == DIV_LAST ? '0 : div + 1'b1) : '0;
            sclk <= en ? sclk ^ edge_tick : CPOL;
        end
endmodule

// File: rtl/spi_master.sv
// spi_master: single-word SPI bus master for all four modes.
// The FSM runs one cycle ahead of the registered pins, so every pin changes one Clk after its state.
module spi_master
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int SPI_MODE   = 0,
    parameter int CLK_DIV    = 4
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  Start,
    input  logic [DATA_WIDTH-1:0] TxData,
    output logic                  Busy,
    output logic                  Done,
    output logic [DATA_WIDTH-1:0] RxData,
    output logic                  SClk,
    output logic                  MOSI,
    output logic                  SS,
    input  logic                  MISO
);
    localparam logic CPOL = spi_cpol(SPI_MODE);
    localparam logic CPHA = spi_cpha(SPI_MODE);
    localparam int CW = $clog2(CLK_DIV);
    localparam int EW = $clog2(2 * DATA_WIDTH);
    localparam logic [CW-1:0] CNT_LAST   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] TRAIL_LAST = CW'(CLK_DIV - 2);
    localparam logic [EW-1:0] EDGE_LAST  = EW'(2 * DATA_WIDTH - 1);

    spi_mst_state_t        state, state_nxt;
    logic [CW-1:0]         cnt;
    logic [EW-1:0]         edges;
    logic [DATA_WIDTH-1:0] tx_sr, rx_sr;
    logic                  fin, tick, leading, last_edge, drive, sample;

    spi_clkgen #(.CLK_DIV(CLK_DIV), .CPOL(CPOL)) u_clkgen (
        .clk      (Clk),
        .rst_n    (Rst_n),
        .en       (state == S_SHIFT),
        .edge_tick(tick),
        .leading  (leading),
        .sclk     (SClk)
    );

    assign last_edge = tick && edges == EDGE_LAST;
    assign sample    = tick && (leading ^ CPHA);
    assign drive     = CPHA ? tick && leading
                            : (state == S_LEAD && cnt == '0) || (tick && !leading && !last_edge);

    // SHIFT leaves on the tick of the last edge, so TRAIL needs one cycle less to keep SClk idle for a full half-period.
    always_comb
        state_nxt = state == S_IDLE  ? (Start ? S_LEAD : S_IDLE) :
                    state == S_LEAD  ? (cnt == CNT_LAST ? S_SHIFT : S_LEAD) :
                    state == S_SHIFT ? (last_edge ? S_TRAIL : S_SHIFT) :
                    state == S_TRAIL ? (cnt == TRAIL_LAST ? S_GAP : S_TRAIL) :
                                       (cnt == CNT_LAST ? S_IDLE : S_GAP);

    always_ff @(posedge Clk or negedge Rst_n)
        if (!Rst_n) begin
            state  <= S_IDLE;
            cnt    <= '0;
            edges  <= '0;
            tx_sr  <= '0;
            rx_sr  <= '0;
            fin    <= 1'b0;
            Busy   <= 1'b0;
            Done   <= 1'b0;
            RxData <= '0;
            MOSI   <= 1'b0;
            SS     <= 1'b1;
        end else begin
            state <= state_nxt;
            cnt   <= state_nxt != state ? '0 : cnt + 1'b1;
            edges <= state == S_IDLE ? '0 : edges + EW'(tick);
            if (state == S_IDLE && Start) begin
                tx_sr <= TxData;
                rx_sr <= '0;
            end else begin
                if (drive) begin
                    MOSI  <= tx_sr[DATA_WIDTH-1];
                    tx_sr <= tx_sr << 1;
                end
                if (sample)
                    rx_sr <= {rx_sr[DATA_WIDTH-2:0], MISO};
            end
            fin  <= state == S_GAP && cnt == CNT_LAST;
            Done <= fin;
            if (fin)
                RxData <= rx_sr;
            Busy <= state != S_IDLE;
            SS   <= !(state inside {S_LEAD, S_SHIFT, S_TRAIL});
        end
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: self-checking bench for spi_master, one instance per SPI mode plus a wide loopback instance.
module tb_spi_master;
    localparam int W = 8;
    localparam int C = 4;
    localparam int SS_RISE  = 1 + (2 * W + 1) * C;
    localparam int DONE_REL = 1 + (2 * W + 2) * C;
    localparam int W16_DONE = 1 + (2 * 16 + 2) * 2;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    logic         start[4];
    logic [W-1:0] tx_data[4];
    logic         busy[4], done[4], sclk[4], mosi[4], ss[4], miso[4];
    logic [W-1:0] rx_data[4];

    logic         start16, busy16, done16, sclk16, mosi16, ss16;
    logic [15:0]  tx16, rx16;

    logic [W-1:0] slave_word[4];
    logic [W-1:0] srx[4];
    int           nsamp[4], nedge[4], done_cnt[4];
    bit           prev_ss[4], prev_sclk[4];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 4; g++) begin : g_m
        spi_master #(.DATA_WIDTH(W), .SPI_MODE(g), .CLK_DIV(C)) dut (
            .Clk(clk), .Rst_n(rst_n), .Start(start[g]), .TxData(tx_data[g]),
            .Busy(busy[g]), .Done(done[g]), .RxData(rx_data[g]), .SClk(sclk[g]),
            .MOSI(mosi[g]), .SS(ss[g]), .MISO(miso[g])
        );
    end

    spi_master #(.DATA_WIDTH(16), .SPI_MODE(0), .CLK_DIV(2)) dut16 (
        .Clk(clk), .Rst_n(rst_n), .Start(start16), .TxData(tx16),
        .Busy(busy16), .Done(done16), .RxData(rx16), .SClk(sclk16),
        .MOSI(mosi16), .SS(ss16), .MISO(mosi16)
    );

    function automatic logic exp_cpol(input int m);
        return m >= 2;
    endfunction

    function automatic logic exp_cpha(input int m);
        return m % 2 == 1;
    endfunction

    // Behavioural slave: sample MOSI and step MISO on whichever SClk edge the mode calls sampling.
    always @(negedge clk)
        for (int i = 0; i < 4; i++) begin
            if (!ss[i]) begin
                if (prev_ss[i]) begin
                    nsamp[i] = 0;
                    nedge[i] = 0;
                    srx[i]   = '0;
                end
                if (sclk[i] != prev_sclk[i]) begin
                    nedge[i]++;
                    if ((sclk[i] != exp_cpol(i)) ^ exp_cpha(i)) begin
                        srx[i] = {srx[i][W-2:0], mosi[i]};
                        nsamp[i]++;
                    end
                end
            end
            miso[i] = nsamp[i] < W ? slave_word[i][W-1-nsamp[i]] : 1'b0;
            if (done[i] === 1'b1) done_cnt[i]++;
            prev_ss[i]   = ss[i];
            prev_sclk[i] = sclk[i];
        end

    task automatic xfer(input int i, input logic [W-1:0] tx, input logic [W-1:0] sw, input string tag);
        int t0, rel, d0, ss_err, busy_err;
        @(negedge clk);
        tx_data[i] = tx; slave_word[i] = sw; start[i] = 1'b1;
        t0 = cyc + 1; d0 = done_cnt[i]; ss_err = 0; busy_err = 0;
        @(negedge clk);
        start[i] = 1'b0; tx_data[i] = ~tx;
        while (done[i] !== 1'b1 && cyc - t0 < 200) begin
            rel = cyc - t0;
            if (ss[i] !== !(rel >= 1 && rel < SS_RISE)) ss_err++;
            if (busy[i] !== (rel >= 1)) busy_err++;
            @(negedge clk);
        end
        rel = cyc - t0;
        n_checks++; if (rel != DONE_REL) begin n_fail++; $display("FAIL %s m%0d done_cycle: got %0d expected %0d", tag, i, rel, DONE_REL); end
        n_checks++; if (rx_data[i] !== sw) begin n_fail++; $display("FAIL %s m%0d master_rx: got %h expected %h", tag, i, rx_data[i], sw); end
        n_checks++; if (srx[i] !== tx) begin n_fail++; $display("FAIL %s m%0d slave_rx: got %h expected %h", tag, i, srx[i], tx); end
        n_checks++; if (nedge[i] != 2 * W) begin n_fail++; $display("FAIL %s m%0d sclk_edges: got %0d expected %0d", tag, i, nedge[i], 2 * W); end
        n_checks++; if (ss_err != 0) begin n_fail++; $display("FAIL %s m%0d ss_window: got %0d bad cycles expected 0", tag, i, ss_err); end
        n_checks++; if (busy_err != 0 || busy[i] !== 1'b0) begin n_fail++; $display("FAIL %s m%0d busy_window: got %0d bad cycles, busy=%b expected 0/0", tag, i, busy_err, busy[i]); end
        n_checks++; if (sclk[i] !== exp_cpol(i) || ss[i] !== 1'b1) begin n_fail++; $display("FAIL %s m%0d idle_pins: got sclk=%b ss=%b expected sclk=%b ss=1", tag, i, sclk[i], ss[i], exp_cpol(i)); end
        @(negedge clk);
        n_checks++; if (done_cnt[i] - d0 != 1 || done[i] !== 1'b0) begin n_fail++; $display("FAIL %s m%0d done_pulse: got %0d pulses done=%b expected 1 pulse done=0", tag, i, done_cnt[i] - d0, done[i]); end
    endtask

    task automatic test_reset;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({ss[i], sclk[i], mosi[i], busy[i], done[i]} !== {1'b1, exp_cpol(i), 3'b000} || rx_data[i] !== '0) begin
                n_fail++;
                $display("FAIL reset m%0d: got ss=%b sclk=%b mosi=%b busy=%b done=%b rx=%h expected 1 %b 0 0 0 00",
                         i, ss[i], sclk[i], mosi[i], busy[i], done[i], rx_data[i], exp_cpol(i));
            end
        end
        n_checks++;
        if ({ss16, sclk16, mosi16, busy16, done16} !== 5'b10000 || rx16 !== '0) begin
            n_fail++;
            $display("FAIL reset w16: got ss=%b sclk=%b mosi=%b busy=%b done=%b rx=%h expected 1 0 0 0 0 0000", ss16, sclk16, mosi16, busy16, done16, rx16);
        end
    endtask

    task automatic test_mode0;
        xfer(0, 8'hA5, 8'h3C, "mode0");
    endtask

    task automatic test_modes;
        for (int i = 1; i < 4; i++) xfer(i, 8'h81, 8'h7E, "modes");
    endtask

    task automatic test_random;
        for (int n = 0; n < 8; n++) xfer(int'($urandom_range(0, 3)), W'($urandom), W'($urandom), "random");
    endtask

    task automatic test_back_to_back;
        int t0, rel, k, run, gaps, min_run;
        logic [W-1:0] sw;
        sw = W'($urandom) | W'(1);
        @(negedge clk);
        slave_word[0] = sw; tx_data[0] = 8'h01; start[0] = 1'b1; t0 = cyc + 1;
        @(negedge clk);
        tx_data[0] = 8'h02;
        k = 0; run = 0; gaps = 0; min_run = 1000;
        while (k < 3 && cyc - t0 < 400) begin
            if (cyc - t0 >= 1) begin
                if (ss[0]) run++;
                else if (run > 0) begin
                    gaps++;
                    min_run = run < min_run ? run : min_run;
                    run = 0;
                end
            end
            if (done[0] === 1'b1) begin
                rel = cyc - t0;
                n_checks++; if (rel != DONE_REL * (k + 1)) begin n_fail++; $display("FAIL b2b done%0d_cycle: got %0d expected %0d", k, rel, DONE_REL * (k + 1)); end
                n_checks++; if (srx[0] !== W'(k + 1)) begin n_fail++; $display("FAIL b2b slave_rx%0d: got %h expected %h", k, srx[0], W'(k + 1)); end
                n_checks++; if (rx_data[0] !== sw) begin n_fail++; $display("FAIL b2b master_rx%0d: got %h expected %h", k, rx_data[0], sw); end
                k++;
                if (k == 1) tx_data[0] = 8'h03;
                if (k == 2) start[0] = 1'b0;
            end
            @(negedge clk);
        end
        start[0] = 1'b0;
        n_checks++; if (k != 3) begin n_fail++; $display("FAIL b2b transfers: got %0d expected 3", k); end
        n_checks++; if (gaps != 2 || min_run < C) begin n_fail++; $display("FAIL b2b ss_gap: got %0d gaps min %0d cycles expected 2 gaps >= %0d", gaps, min_run, C); end
    endtask

    task automatic test_busy_ignore;
        int t0, rel, d0;
        logic [W-1:0] sw;
        sw = W'($urandom);
        @(negedge clk);
        tx_data[1] = 8'h96; slave_word[1] = sw; start[1] = 1'b1; t0 = cyc + 1; d0 = done_cnt[1];
        @(negedge clk);
        start[1] = 1'b0; tx_data[1] = 8'h69;
        while (done[1] !== 1'b1 && cyc - t0 < 200) begin
            start[1] = (cyc - t0 == 20);
            @(negedge clk);
        end
        start[1] = 1'b0;
        rel = cyc - t0;
        n_checks++; if (rel != DONE_REL) begin n_fail++; $display("FAIL busy_ignore done_cycle: got %0d expected %0d", rel, DONE_REL); end
        n_checks++; if (srx[1] !== 8'h96 || rx_data[1] !== sw) begin n_fail++; $display("FAIL busy_ignore data: got slave %h master %h expected 96 %h", srx[1], rx_data[1], sw); end
        repeat (120) @(negedge clk);
        n_checks++; if (done_cnt[1] - d0 != 1 || busy[1] !== 1'b0) begin n_fail++; $display("FAIL busy_ignore extra: got %0d pulses busy=%b expected 1 pulse busy=0", done_cnt[1] - d0, busy[1]); end
    endtask

    task automatic test_reset_abort;
        int t0, d0, d2;
        @(negedge clk);
        tx_data[0] = 8'hC3; tx_data[2] = 8'h5A; slave_word[0] = 8'hF0; slave_word[2] = 8'h0F;
        start[0] = 1'b1; start[2] = 1'b1; t0 = cyc + 1; d0 = done_cnt[0]; d2 = done_cnt[2];
        @(negedge clk);
        start[0] = 1'b0; start[2] = 1'b0;
        while (cyc - t0 < 30) @(negedge clk);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i += 2) begin
            n_checks++;
            if ({ss[i], sclk[i], busy[i], done[i], mosi[i]} !== {1'b1, exp_cpol(i), 3'b000} || rx_data[i] !== '0) begin
                n_fail++;
                $display("FAIL abort m%0d pins: got ss=%b sclk=%b busy=%b done=%b mosi=%b rx=%h expected 1 %b 0 0 0 00",
                         i, ss[i], sclk[i], busy[i], done[i], mosi[i], rx_data[i], exp_cpol(i));
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        n_checks++; if (done_cnt[0] != d0 || done_cnt[2] != d2) begin n_fail++; $display("FAIL abort no_done: got %0d/%0d pulses expected 0/0", done_cnt[0] - d0, done_cnt[2] - d2); end
        xfer(0, 8'h55, W'($urandom), "after_abort");
    endtask

    task automatic test_wide_loopback;
        int t0, rel;
        logic [15:0] w;
        for (int k = 0; k < 2; k++) begin
            w = k == 0 ? 16'hBEEF : 16'($urandom);
            @(negedge clk);
            tx16 = w; start16 = 1'b1; t0 = cyc + 1;
            @(negedge clk);
            start16 = 1'b0; tx16 = ~w;
            while (done16 !== 1'b1 && cyc - t0 < 200) @(negedge clk);
            rel = cyc - t0;
            n_checks++; if (rel != W16_DONE) begin n_fail++; $display("FAIL wide done_cycle: got %0d expected %0d", rel, W16_DONE); end
            n_checks++; if (rx16 !== w) begin n_fail++; $display("FAIL wide loopback_rx: got %h expected %h", rx16, w); end
            n_checks++; if (ss16 !== 1'b1 || sclk16 !== 1'b0 || busy16 !== 1'b0) begin n_fail++; $display("FAIL wide idle_pins: got ss=%b sclk=%b busy=%b expected 1 0 0", ss16, sclk16, busy16); end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start16 = 1'b0;
        tx16 = '0;
        for (int i = 0; i < 4; i++) begin
            start[i] = 1'b0;
            tx_data[i] = '0;
            slave_word[i] = '0;
        end
        repeat (3) @(negedge clk);
        test_reset;
        rst_n = 1'b1;
        test_mode0;
        test_modes;
        test_random;
        test_back_to_back;
        test_busy_ignore;
        test_reset_abort;
        test_wide_loopback;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/spi_master.md
# spi_master

SPI bus master that serialises one `DATA_WIDTH`-bit word onto MOSI while capturing a word of the same width from MISO. Generates SClk and SS from the system clock for all four SPI modes. Sits between the on-chip control logic (single-word Start/Done handshake) and the external SPI pins. It is the initiating end of the bus served by the team's `spi_slave`.

## Interface
- `DATA_WIDTH`, 8: bits per transfer, ≥ 2.
- `SPI_MODE`, 0: 0–3. ClkPol = mode 2/3; ClkPha = mode 1/3.
- `CLK_DIV`, 4: system clocks per SClk half-period, ≥ 2.
- `Clk` input 1: system clock; all state updates on rising edge. One clock only.
- `Rst_n` input 1: asynchronous, active-low reset.
- `Start` input 1: request a transfer. Sampled only while Busy=0.
- `TxData` input DATA_WIDTH: word to send. Captured on the cycle Start is accepted.
- `Busy` output 1: high from the cycle after Start is accepted until Done.
- `Done` output 1: one-cycle pulse when the transfer completes.
- `RxData` output DATA_WIDTH: received word. Valid from the Done cycle and held until the next Done.
- `SClk` output 1: SPI clock; idles at ClkPol.
- `MOSI` output 1: master data out, MSB first.
- `SS` output 1: active-low slave select.
- `MISO` input 1: slave data in.

## Operation
- FSM states: IDLE → LEAD → SHIFT → TRAIL → GAP → IDLE.
- **IDLE**
  - SS=1, SClk=ClkPol.
  - Start=1 loads TxData into the tx shift register, clears the edge counter and goes to LEAD.
- **LEAD** (CLK_DIV cycles)
  - SS=0, Busy=1.
  - ClkPha=0: MOSI = TxData MSB from the first LEAD cycle.
- **SHIFT**
  - A divider counter toggles SClk every CLK_DIV cycles, for 2·DATA_WIDTH edges in total.
  - Odd-numbered edges are leading; even-numbered edges are trailing.
  - ClkPha=0: sample MISO into the rx shift register on leading edges; advance MOSI to the next bit on trailing edges, except the final trailing edge.
  - ClkPha=1: drive the next MOSI bit on leading edges, starting with the MSB on edge 1; sample MISO on trailing edges.
- **TRAIL** (CLK_DIV cycles)
  - SClk back at idle level, SS still 0.
- **GAP** (CLK_DIV cycles)
  - SS=1, guaranteeing minimum SS-high time.
  - On the last GAP cycle: RxData ← rx shift register, Done=1, Busy=0, next state IDLE.
- Start is ignored while Busy=1. Start held high produces back-to-back transfers, each separated by the GAP.
- MOSI holds its last value between transfers.
- Reset (any state, asynchronous): SS=1, SClk=ClkPol, MOSI=0, Busy=0, Done=0, RxData=0, FSM=IDLE.
  - An aborted transfer produces no Done.
  - Partial rx data is discarded.

## Timing
- Start accepted at cycle 0 (the edge that samples Start=1). Cycle numbers below are relative to that.
- SS falls at cycle 1.
- SClk edge k (1..2W) occurs at cycle 1 + k·CLK_DIV.
- SS rises at 1 + (2W+1)·CLK_DIV.
- Done pulse at 1 + (2W+2)·CLK_DIV.
  - Default parameters: SS low at 1, first edge at 5, last edge at 65, SS high at 69, Done at 73.
- All pin outputs are registered; there is no combinational path from MISO or Start to any output.
- MISO is sampled on the same Clk edge that produces the sampling SClk edge.
- SClk frequency = Clk / (2·CLK_DIV).

## Structure
- Shared package `spi_pkg`:
  - mode decode functions `spi_cpol(mode)` and `spi_cpha(mode)`;
  - FSM state enum `spi_mst_state_t`.
  - `spi_slave` is refactored later to use the same decode.
- One sub-module, `spi_clkgen`:
  - half-period counter producing a one-cycle `edge_tick`, a `leading` flag and the registered SClk;
  - enabled only in SHIFT.
- Shift registers, edge counter and FSM live in `spi_master`.

## Test plan
- Mode 0, TxData=0xA5, `spi_slave` (mode 0) loaded with 0x3C → Done at cycle 73; master RxData=0x3C; slave RxData=0xA5; SS low for cycles 1–68.
- Modes 1, 2, 3, each with TxData=0x81 and slave word 0x7E → both sides exchange correctly; SClk idles at 1 in modes 2/3; exactly 16 SClk edges per transfer.
- Start held high for 3 transfers (0x01, 0x02, 0x03) → three Done pulses 73 cycles apart; SS high ≥ CLK_DIV cycles between transfers; Start pulse during Busy has no effect.
- Rst_n pulled low at cycle 30 of a transfer → SS=1, SClk=ClkPol, Busy=0 immediately; no Done; next transfer 0x55 completes normally.
- CLK_DIV=2, DATA_WIDTH=16, TxData=0xBEEF, MISO looped back to MOSI → RxData=0xBEEF; Done at cycle 1 + 34·2 = 69.
